next_pc_unit: RTL

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/next_pc_unit.sv
// next_pc_unit -- program-counter sequencer with a circular return-address stack.
//
// Picks the next fetch address from sequential, branch, j/jal and jr sources.
// Keeps a RAS (jal pushes, jr pops), flags mispredicted returns and misaligned
// jr targets, and counts retired (advanced) instructions.
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_pc_ready, i_stall   fetch handshake; stall overrides ready
//   i_jump                00 none, 01 j, 10 jal, 11 jr
//   i_branch_taken        taken conditional branch
//   i_branch_offset       sign-extended word offset
//   i_jump_target         instr[25:0]
//   i_reg_target          rs value for jr
//   o_pc, o_pc_valid      current fetch address and its valid flag
//   o_link_addr           pc+4 (combinational)
//   o_ras_top, o_ras_count  RAS top entry (0 when empty) and occupancy
//   o_ras_mispredict      one-cycle pulse after a mispredicted jr
//   o_misalign_err        sticky misaligned-jr flag
//   o_retired             advanced-instruction counter, wraps
module next_pc_unit #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                 RAS_DEPTH    = 4,
  localparam int                AW           = $clog2(RAS_DEPTH),
  localparam int                CW           = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pc_ready,
  input  logic             i_stall,
  input  logic [1:0]       i_jump,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_offset,
  input  logic [25:0]      i_jump_target,
  input  logic [WIDTH-1:0] i_reg_target,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_pc_valid,
  output logic [WIDTH-1:0] o_link_addr,
  output logic [WIDTH-1:0] o_ras_top,
  output logic [CW-1:0]    o_ras_count,
  output logic             o_ras_mispredict,
  output logic             o_misalign_err,
  output logic [31:0]      o_retired
);

  localparam logic [1:0] J_J = 2'b01, J_JAL = 2'b10, J_JR = 2'b11;

  logic [WIDTH-1:0] r_pc;
  logic             r_valid;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [AW-1:0]    r_sp;      // next write slot; top is r_sp-1
  logic [CW-1:0]    r_count;
  logic             r_mispredict;
  logic             r_misalign;
  logic [31:0]      r_retired;

  logic             w_advance;
  logic [WIDTH-1:0] w_link, w_br_tgt, w_j_tgt, w_jr_tgt, w_next_pc, w_ras_top;
  logic [AW-1:0]    w_top_idx;
  logic             w_push, w_pop, w_jr;

  assign w_advance = r_valid & i_pc_ready & ~i_stall;
  assign w_link    = r_pc + WIDTH'(4);
  assign w_br_tgt  = w_link + (i_branch_offset << 2);
  assign w_jr_tgt  = {i_reg_target[WIDTH-1:2], 2'b00};

  // At WIDTH=28 the region bits above the 28-bit jump window do not exist.
  generate
    if (WIDTH > 28) begin : g_jregion
      assign w_j_tgt = {w_link[WIDTH-1:28], i_jump_target, 2'b00};
    end else begin : g_jflat
      assign w_j_tgt = {i_jump_target, 2'b00};
    end
  endgenerate

  assign w_top_idx = r_sp - 1'b1;
  assign w_ras_top = (r_count != '0) ? r_ras[w_top_idx] : '0;

  assign w_jr   = w_advance & (i_jump == J_JR);
  assign w_push = w_advance & (i_jump == J_JAL);
  assign w_pop  = w_jr & (r_count != '0);

  always_comb begin
    w_next_pc = w_link;
    if (i_jump == J_JR)                          w_next_pc = w_jr_tgt;
    else if (i_jump == J_J || i_jump == J_JAL)   w_next_pc = w_j_tgt;
    else if (i_branch_taken)                     w_next_pc = w_br_tgt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc      <= RESET_VECTOR;
      r_valid   <= 1'b0;
      r_retired <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_valid <= 1'b1;
      if (w_advance) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
      end
      if (w_jr && i_reg_target[1:0] != 2'b00) r_misalign <= 1'b1;
    end
  end

  // Circular RAS: when full, a push lands on the oldest slot (r_sp wraps onto
  // it) and the count saturates, so the deepest return is silently lost.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      r_sp         <= '0;
      r_count      <= '0;
      r_mispredict <= 1'b0;
    end else begin
      r_mispredict <= w_pop & (w_ras_top != w_jr_tgt);
      if (w_push) begin
        r_ras[r_sp] <= w_link;
        r_sp        <= r_sp + 1'b1;
        if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_sp    <= r_sp - 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_pc             = r_pc;
  assign o_pc_valid       = r_valid;
  assign o_link_addr      = w_link;
  assign o_ras_top        = w_ras_top;
  assign o_ras_count      = r_count;
  assign o_ras_mispredict = r_mispredict;
  assign o_misalign_err   = r_misalign;
  assign o_retired        = r_retired;

endmodule
